// File: rtl/enemy_march_pacer_if.sv
// Handshake bundle between the march pacer and its surroundings.
// The master side drives the game controls and the formation x position.
// The slave side (the pacer) returns the step/drop pulses, direction and period.
interface enemy_march_pacer_if #(
    parameter int CNT_W = 24
) ();

    logic             enable;
    logic             pause;
    logic             kill;
    logic             wave_reset;
    logic [10:0]      posxE1;
    logic             mueva;
    logic             drop;
    logic             dir;
    logic [CNT_W-1:0] period;

    modport master (
        output enable,
        output pause,
        output kill,
        output wave_reset,
        output posxE1,
        input  mueva,
        input  drop,
        input  dir,
        input  period
    );

    modport slave (
        input  enable,
        input  pause,
        input  kill,
        input  wave_reset,
        input  posxE1,
        output mueva,
        output drop,
        output dir,
        output period
    );

endinterface

// File: rtl/enemy_march_pacer.sv
// Timing and direction master for the enemy formation.
// A period counter produces one-cycle step pulses (mueva). When a step falls
// due while the formation sits at a screen edge, a drop pulse is issued
// instead and the march direction reverses. Kills shorten the period down to
// a floor, and a wave restart restores the base period and rightward march.
module enemy_march_pacer #(
    parameter int CNT_W       = 24,
    parameter int BASE_PERIOD = 12500000,
    parameter int MIN_PERIOD  = 1250000,
    parameter int STEP_DEC    = 250000,
    parameter int X_MIN       = 16,
    parameter int X_MAX       = 560
) (
    input logic                clk,
    input logic                reset,
    enemy_march_pacer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_R = 2'd1,
        ST_RUN_L = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BASE_P   = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] DEC_P    = CNT_W'(STEP_DEC);
    localparam logic [CNT_W-1:0] ONE_P    = CNT_W'(1);
    // Smallest period that can absorb a full decrement without going under
    // the floor; one bit wider so MIN_PERIOD + STEP_DEC cannot wrap.
    localparam logic [CNT_W:0]   KILL_LIM = (CNT_W+1)'(MIN_PERIOD) + (CNT_W+1)'(STEP_DEC);
    localparam logic [10:0]      X_LO     = 11'(X_MIN);
    localparam logic [10:0]      X_HI     = 11'(X_MAX);

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] period_r;
    logic             dir_r;
    logic             mueva_r;
    logic             drop_r;

    logic [CNT_W-1:0] period_last_s;
    logic             tick_due_s;
    logic             at_right_s;
    logic             at_left_s;
    logic [CNT_W-1:0] period_killed_s;

    // Tick and screen-edge detection from the current count and position.
    always_comb begin
        period_last_s = period_r - ONE_P;
        // >= so a period that shrank below the running count fires at once.
        tick_due_s    = (cnt_r >= period_last_s);
        at_right_s    = (bus.posxE1 >= X_HI);
        at_left_s     = (bus.posxE1 <= X_LO);
    end

    // Saturating period reduction applied on a kill; compare before subtract.
    always_comb begin
        period_killed_s = period_r;
        if ({1'b0, period_r} >= KILL_LIM) begin
            period_killed_s = period_r - DEC_P;
        end else begin
            period_killed_s = MIN_P;
        end
    end

    // Pacer state machine with counter, direction, period and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            period_r <= BASE_P;
            dir_r    <= 1'b1;
            mueva_r  <= 1'b0;
            drop_r   <= 1'b0;
        end else if (bus.wave_reset) begin
            // A new wave outranks a kill and discards any tick due now.
            state_r  <= bus.enable ? ST_RUN_R : ST_IDLE;
            cnt_r    <= '0;
            period_r <= BASE_P;
            dir_r    <= 1'b1;
            mueva_r  <= 1'b0;
            drop_r   <= 1'b0;
        end else begin
            // Kills are taken in every state; a tick this cycle still
            // compared against the old period above.
            if (bus.kill) begin
                period_r <= period_killed_s;
            end else begin
                period_r <= period_r;
            end

            if (!bus.enable) begin
                state_r <= ST_IDLE;
                cnt_r   <= '0;
                mueva_r <= 1'b0;
                drop_r  <= 1'b0;
            end else if (bus.pause) begin
                // Freeze count, state and direction; a due tick waits.
                mueva_r <= 1'b0;
                drop_r  <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r <= dir_r ? ST_RUN_R : ST_RUN_L;
                        cnt_r   <= '0;
                        mueva_r <= 1'b0;
                        drop_r  <= 1'b0;
                    end
                    ST_RUN_R: begin
                        if (tick_due_s) begin
                            cnt_r <= '0;
                            if (at_right_s) begin
                                state_r <= ST_RUN_L;
                                dir_r   <= 1'b0;
                                mueva_r <= 1'b0;
                                drop_r  <= 1'b1;
                            end else begin
                                mueva_r <= 1'b1;
                                drop_r  <= 1'b0;
                            end
                        end else begin
                            cnt_r   <= cnt_r + ONE_P;
                            mueva_r <= 1'b0;
                            drop_r  <= 1'b0;
                        end
                    end
                    ST_RUN_L: begin
                        if (tick_due_s) begin
                            cnt_r <= '0;
                            if (at_left_s) begin
                                state_r <= ST_RUN_R;
                                dir_r   <= 1'b1;
                                mueva_r <= 1'b0;
                                drop_r  <= 1'b1;
                            end else begin
                                mueva_r <= 1'b1;
                                drop_r  <= 1'b0;
                            end
                        end else begin
                            cnt_r   <= cnt_r + ONE_P;
                            mueva_r <= 1'b0;
                            drop_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        cnt_r   <= '0;
                        mueva_r <= 1'b0;
                        drop_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.mueva  = mueva_r;
    assign bus.drop   = drop_r;
    assign bus.dir    = dir_r;
    assign bus.period = period_r;

endmodule

// File: tb/tb_enemy_march_pacer.sv
// Scoreboard bench for enemy_march_pacer (BASE=8, MIN=3, DEC=2, X_MIN=10, X_MAX=100).
// Stimulus pushes expected pulses (kind, cycle, dir, period); a negedge monitor
// pops and compares whenever mueva or drop is high.
module tb_enemy_march_pacer;

    localparam int CNT_W = 24;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        bit is_drop;
        int at;
        bit dir;
        int period;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    enemy_march_pacer_if #(.CNT_W(CNT_W)) bus ();

    enemy_march_pacer #(
        .CNT_W(CNT_W), .BASE_PERIOD(8), .MIN_PERIOD(3),
        .STEP_DEC(2), .X_MIN(10), .X_MAX(100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic push(input bit d, input int at, input bit dr, input int p);
        sb_q.push_back(exp_t'{d, at, dr, p});
    endtask

    // Monitor: flag missed pulses, then check every presented pulse.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].at < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL missed_pulse: got none required %s at cycle %0d (now %0d)",
                     sb_q[0].is_drop ? "drop" : "mueva", sb_q[0].at, cyc);
            void'(sb_q.pop_front());
        end
        if (bus.mueva || bus.drop) begin
            chk("pulse_exclusive", int'(bus.mueva && bus.drop), 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pulse_kind_drop", int'(bus.drop), int'(mon_e.is_drop));
                chk("pulse_cycle", cyc, mon_e.at);
                chk("pulse_dir", int'(bus.dir), int'(mon_e.dir));
                chk("pulse_period", int'(bus.period), mon_e.period);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish required finish before 100000");
        $fatal(1, "timeout");
    end

    initial begin
        bus.enable     = 1'b0;
        bus.pause      = 1'b0;
        bus.kill       = 1'b0;
        bus.wave_reset = 1'b0;
        bus.posxE1     = 11'd50;
        reset          = 1'b1;
        step(3);

        // 1. reset values, then steady marching at period 8
        chk("reset_mueva", int'(bus.mueva), 0);
        chk("reset_drop", int'(bus.drop), 0);
        chk("reset_dir", int'(bus.dir), 1);
        chk("reset_period", int'(bus.period), 8);
        reset      = 1'b0;
        bus.enable = 1'b1;          // RUN_R entered at edge 4
        push(1'b0, 12, 1'b1, 8);
        push(1'b0, 20, 1'b1, 8);
        push(1'b0, 28, 1'b1, 8);

        // 2. right edge, left march, left edge
        wait_until(32); bus.posxE1 = 11'd100; push(1'b1, 36, 1'b0, 8);
        wait_until(40); bus.posxE1 = 11'd60;  push(1'b0, 44, 1'b0, 8);
        wait_until(48); bus.posxE1 = 11'd10;  push(1'b1, 52, 1'b1, 8);
        wait_until(56); bus.posxE1 = 11'd50;  push(1'b0, 60, 1'b1, 8);
        wait_until(60);

        // 3. kills right after ticks: period 6, 4, 3, 3 sets pulse spacing
        bus.kill = 1'b1; push(1'b0, 66, 1'b1, 6); step(1); bus.kill = 1'b0; wait_until(66);
        bus.kill = 1'b1; push(1'b0, 70, 1'b1, 4); step(1); bus.kill = 1'b0; wait_until(70);
        bus.kill = 1'b1; push(1'b0, 73, 1'b1, 3); step(1); bus.kill = 1'b0; wait_until(73);
        bus.kill = 1'b1; push(1'b0, 76, 1'b1, 3); step(1); bus.kill = 1'b0;
        chk("period_floor", int'(bus.period), 3);
        wait_until(76);

        // 4. pause 20 clocks at count 1: span becomes 3 + 20
        step(1);
        push(1'b0, 99, 1'b1, 3);
        bus.pause = 1'b1;
        step(20);
        bus.pause = 1'b0;
        wait_until(99);

        // 5. flip to left, then wave_reset + kill on a due tick
        bus.posxE1 = 11'd100; push(1'b1, 102, 1'b0, 3);
        wait_until(102); bus.posxE1 = 11'd50;
        wait_until(104);
        bus.wave_reset = 1'b1;
        bus.kill       = 1'b1;
        step(1);
        bus.wave_reset = 1'b0;
        bus.kill       = 1'b0;
        chk("wave_period", int'(bus.period), 8);
        chk("wave_dir", int'(bus.dir), 1);
        push(1'b0, 113, 1'b1, 8);
        wait_until(113);

        // 3b. kill as the count reaches 6: period 6 fires on the next clock
        wait_until(118);
        bus.kill = 1'b1; push(1'b0, 120, 1'b1, 6); step(1); bus.kill = 1'b0;
        wait_until(120);

        // 6. reset mid-period with dir=0 and enable held high
        bus.posxE1 = 11'd100; push(1'b1, 126, 1'b0, 6);
        wait_until(126); bus.posxE1 = 11'd50;
        step(2);
        reset = 1'b1;
        step(1);
        chk("rst2_mueva", int'(bus.mueva), 0);
        chk("rst2_drop", int'(bus.drop), 0);
        chk("rst2_dir", int'(bus.dir), 1);
        chk("rst2_period", int'(bus.period), 8);
        reset = 1'b0;               // IDLE now, RUN_R at edge 130
        push(1'b0, 138, 1'b1, 8);
        wait_until(141);

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/enemy_march_pacer.md
Name: enemy_march_pacer

Overview:
Timing and direction master for the enemy formation. It generates the one-cycle `mueva` step pulses consumed by the enemy movement logic, and reads back that logic's `posxE1` to decide when the formation has hit a screen edge. At an edge it issues a drop pulse and reverses direction. The step period shortens as enemies are killed, and a wave restart restores it.

Parameters:
CNT_W, 24, width of the period counter and of `period`
BASE_PERIOD, 12500000, clocks between steps at wave start (0.25 s at 50 MHz)
MIN_PERIOD, 1250000, floor for the step period
STEP_DEC, 250000, period reduction per kill
X_MIN, 16, left edge threshold for `posxE1`
X_MAX, 560, right edge threshold for `posxE1`

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high reset
enable  in  1  game running; low forces IDLE
pause  in  1  freezes the counter, pulses and state
kill  in  1  one-cycle pulse, one enemy destroyed
wave_reset  in  1  one-cycle pulse, new wave starts
posxE1  in  11  current formation x position, fed back from movement logic
mueva  out  1  one-cycle step pulse to movement logic
drop  out  1  one-cycle pulse: formation moves down one row
dir  out  1  1 = moving right, 0 = moving left
period  out  CNT_W  current step period in clocks

Behaviour:
- Reset (when `reset` is high at a clk edge):
  - `mueva` = 0, `drop` = 0, `dir` = 1, `period` = BASE_PERIOD.
  - Counter = 0, state = IDLE.
- States: IDLE, RUN_R, RUN_L.
  - IDLE -> RUN_R or RUN_L (chosen by the current `dir`) when `enable` = 1.
  - Any state -> IDLE when `enable` = 0. The counter clears; `dir` and `period` are kept.
- Counting in RUN_* with `pause` = 0:
  - Counter increments each clock.
  - When counter >= `period` - 1, a tick occurs and the counter clears to 0 on the same edge.
  - Use >= so that a period shrinking below the current count fires on the next clock.
- `pause` = 1: counter, state and `dir` are held. `mueva` and `drop` are forced to 0. A tick due during the pause fires on the first unpaused cycle.
- Tick action, with `posxE1` sampled on the tick cycle:
  - RUN_R and `posxE1` >= X_MAX: `drop` = 1 for the next cycle, `mueva` = 0, `dir` <= 0, state -> RUN_L.
  - RUN_L and `posxE1` <= X_MIN: `drop` = 1, `mueva` = 0, `dir` <= 1, state -> RUN_R.
  - Otherwise: `mueva` = 1 for exactly one cycle.
- Outputs are registered. A pulse appears in the cycle after the tick edge and lasts 1 clock. `mueva` and `drop` are never high together.
- `kill`:
  - `period` <= `period` - STEP_DEC if that result is >= MIN_PERIOD, else MIN_PERIOD.
  - Use saturating, width-safe arithmetic; compare before subtracting so there is no underflow.
  - Accepted in any state, including during pause.
- `wave_reset`:
  - `period` <= BASE_PERIOD, `dir` <= 1, counter <= 0, pending pulses are cleared.
  - State -> RUN_R if `enable`, else IDLE.
- Simultaneous events:
  - `reset` > `wave_reset` > `kill`.
  - `wave_reset` + tick in the same cycle: the tick is discarded.
  - `kill` + tick in the same cycle: the tick uses the old period; the new period applies from the next count.
- Parameter legality: MIN_PERIOD >= 2, BASE_PERIOD >= MIN_PERIOD, X_MIN < X_MAX < 2048, BASE_PERIOD < 2^CNT_W.

Test Plan:
(Bench parameters: BASE_PERIOD=8, MIN_PERIOD=3, STEP_DEC=2, X_MIN=10, X_MAX=100.)
1. Reset, enable=1, `posxE1`=50 held -> `mueva` pulses exactly every 8 clocks; `drop`=0, `dir`=1, `period`=8.
2. `posxE1`=100 at a tick in RUN_R -> `drop` single pulse, no `mueva`, `dir`=0. Next tick with `posxE1`=60 -> `mueva` pulse. At `posxE1`=10 -> `drop` pulse, `dir`=1.
3. Three `kill` pulses -> `period` goes 6, 4, 3, and a fourth kill leaves it at 3. Spacing of `mueva` pulses shrinks to match. A kill with counter=6 and period 8->6 -> tick fires on the next clock.
4. `pause` held 20 clocks mid-count -> no pulses and counter frozen. Release -> the tick fires after the remaining count, total span = period + 20.
5. `wave_reset` and `kill` in the same cycle while `dir`=0, `period`=3 -> `period`=8, `dir`=1, counter 0, next `mueva` 8 clocks later.
6. `reset` asserted mid-period with `dir`=0 and `enable` still 1 -> the next clock shows all outputs at reset values. After release, the state passes through IDLE to RUN_R, and the first `mueva` comes BASE_PERIOD clocks after the RUN_R entry.
